// File: rtl/mipi_pkg.sv
// Shared types and constants for the single-lane DSI transmitter.
package mipi_pkg;

  typedef enum logic [4:0] {
    IDLE,
    CLK_LP01, CLK_LP00, CLK_PREP, CLK_ZERO, CLK_PRE,
    D_LP01, D_LP00, D_PREP, D_ZERO, D_SYNC, D_DATA, D_TRAIL, D_EXIT,
    CLK_POST, CLK_TRAIL, CLK_EXIT
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  // LP pair codes as {p, n}
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  localparam int unsigned DEF_DEPTH      = 256;
  localparam int unsigned DEF_T_LPX      = 8;
  localparam int unsigned DEF_T_PREP     = 8;
  localparam int unsigned DEF_T_ZERO     = 16;
  localparam int unsigned DEF_T_TRAIL    = 16;
  localparam int unsigned DEF_T_CLK_PRE  = 16;
  localparam int unsigned DEF_T_CLK_POST = 16;

  // Clock lane toggles from CLK_PRE up to (not including) CLK_TRAIL.
  function automatic logic clk_running(input state_t s);
    return s inside {CLK_PRE, D_LP01, D_LP00, D_PREP, D_ZERO, D_SYNC,
                     D_DATA, D_TRAIL, D_EXIT, CLK_POST};
  endfunction

endpackage

// File: rtl/mipi_frame_buf.sv
// Frame byte buffer: sequential writes with saturating count, sequential reads.
module mipi_frame_buf
  import mipi_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic [AW:0]   count,
  output logic          rd_done
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] rd_ptr;
  logic        wr_ok;

  assign wr_ok   = wr_en && (count != FULL);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign rd_done = (rd_ptr == count);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[count[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      count  <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) count  <= count + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/mipi_dsi_tx.sv
// Single-lane D-PHY/DSI transmitter: buffers one SLIP frame, sends it as one HS burst.
module mipi_dsi_tx
  import mipi_pkg::*;
#(
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned T_LPX      = DEF_T_LPX,
  parameter int unsigned T_PREP     = DEF_T_PREP,
  parameter int unsigned T_ZERO     = DEF_T_ZERO,
  parameter int unsigned T_TRAIL    = DEF_T_TRAIL,
  parameter int unsigned T_CLK_PRE  = DEF_T_CLK_PRE,
  parameter int unsigned T_CLK_POST = DEF_T_CLK_POST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d_in,
  input  logic       d_req,
  output logic       d_ack,
  input  logic       b_req,
  output logic       d_hs,
  output logic       c_hs,
  output logic       d_lp_p,
  output logic       d_lp_n,
  output logic       c_lp_p,
  output logic       c_lp_n
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [15:0] L_LPX   = 16'(T_LPX - 1);
  localparam logic [15:0] L_PREP  = 16'(T_PREP - 1);
  localparam logic [15:0] L_ZERO  = 16'(T_ZERO - 1);
  localparam logic [15:0] L_TRAIL = 16'(T_TRAIL - 1);
  localparam logic [15:0] L_CPRE  = 16'(T_CLK_PRE - 1);
  localparam logic [15:0] L_CPOST = 16'(T_CLK_POST - 1);
  localparam logic [15:0] L_BITS  = 16'd7;

  state_t      state;
  logic [15:0] cnt;
  logic [7:0]  sh;
  logic [AW:0] count;
  logic [7:0]  rd_data;
  logic        rd_done;
  logic        rd_en;
  logic        buf_clr;

  assign d_ack = d_req & b_req & (state == IDLE);

  always_comb begin
    rd_en   = (cnt == '0) && ((state == D_SYNC) || (state == D_DATA && !rd_done));
    buf_clr = (state == CLK_EXIT);
  end

  mipi_frame_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .wr_en   (d_ack),
    .wr_data (d_in),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count),
    .rd_done (rd_done)
  );

  // Outputs are set on the edge that enters a state, so each state's levels
  // appear for exactly its counted cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      sh               <= '0;
      d_hs             <= 1'b0;
      c_hs             <= 1'b0;
      {d_lp_p, d_lp_n} <= LP11;
      {c_lp_p, c_lp_n} <= LP11;
    end else begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      if (clk_running(state)) c_hs <= ~c_hs;
      case (state)
        IDLE: if (!b_req && count != '0) begin
          state <= CLK_LP01; cnt <= L_LPX; {c_lp_p, c_lp_n} <= LP01;
        end
        CLK_LP01: if (cnt == '0) begin
          state <= CLK_LP00; cnt <= L_LPX; {c_lp_p, c_lp_n} <= LP00;
        end
        CLK_LP00: if (cnt == '0) begin state <= CLK_PREP; cnt <= L_PREP; end
        CLK_PREP: if (cnt == '0) begin state <= CLK_ZERO; cnt <= L_ZERO; end
        CLK_ZERO: if (cnt == '0) begin
          state <= CLK_PRE; cnt <= L_CPRE; c_hs <= 1'b1;
        end
        CLK_PRE: if (cnt == '0) begin
          state <= D_LP01; cnt <= L_LPX; {d_lp_p, d_lp_n} <= LP01;
        end
        D_LP01: if (cnt == '0) begin
          state <= D_LP00; cnt <= L_LPX; {d_lp_p, d_lp_n} <= LP00;
        end
        D_LP00: if (cnt == '0) begin state <= D_PREP; cnt <= L_PREP; end
        D_PREP: if (cnt == '0) begin state <= D_ZERO; cnt <= L_ZERO; end
        D_ZERO: if (cnt == '0) begin
          state <= D_SYNC; cnt <= L_BITS;
          d_hs  <= SYNC_BYTE[0]; sh <= {1'b0, SYNC_BYTE[7:1]};
        end
        D_SYNC, D_DATA: begin
          if (cnt != '0) begin
            d_hs <= sh[0]; sh <= {1'b0, sh[7:1]};
          end else if (state == D_DATA && rd_done) begin
            state <= D_TRAIL; cnt <= L_TRAIL; d_hs <= ~d_hs;
          end else begin
            state <= D_DATA; cnt <= L_BITS;
            d_hs  <= rd_data[0]; sh <= {1'b0, rd_data[7:1]};
          end
        end
        D_TRAIL: if (cnt == '0) begin
          state <= D_EXIT; d_hs <= 1'b0; {d_lp_p, d_lp_n} <= LP11;
        end
        D_EXIT: begin state <= CLK_POST; cnt <= L_CPOST; end
        CLK_POST: if (cnt == '0) begin
          state <= CLK_TRAIL; cnt <= L_TRAIL; c_hs <= 1'b0;
        end
        CLK_TRAIL: if (cnt == '0) begin
          state <= CLK_EXIT; {c_lp_p, c_lp_n} <= LP11;
        end
        CLK_EXIT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_dsi_tx.sv
// Scoreboard bench for mipi_dsi_tx: per-cycle expected lane levels queued at stimulus time.
module tb_mipi_dsi_tx;

  localparam int DEPTH      = 256;
  localparam int T_LPX      = 8;
  localparam int T_PREP     = 8;
  localparam int T_ZERO     = 16;
  localparam int T_TRAIL    = 16;
  localparam int T_CLK_PRE  = 16;
  localparam int T_CLK_POST = 16;

  // {d_lp_p, d_lp_n, c_lp_p, c_lp_n, d_hs, c_hs, d_ack}
  localparam logic [6:0] IDLE_V = 7'b1111_000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d_in = '0;
  logic       d_req = 1'b0;
  logic       b_req = 1'b0;
  logic       d_ack, d_hs, c_hs, d_lp_p, d_lp_n, c_lp_p, c_lp_n;
  logic [6:0] obs;

  int n_chk = 0;
  int n_err = 0;
  logic [6:0] exp_q[$];
  logic [7:0] frm[$];
  logic       tg;

  assign obs = {d_lp_p, d_lp_n, c_lp_p, c_lp_n, d_hs, c_hs, d_ack};

  always #5 clk = ~clk;

  mipi_dsi_tx #(
    .DEPTH(DEPTH), .T_LPX(T_LPX), .T_PREP(T_PREP), .T_ZERO(T_ZERO),
    .T_TRAIL(T_TRAIL), .T_CLK_PRE(T_CLK_PRE), .T_CLK_POST(T_CLK_POST)
  ) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .d_req(d_req), .d_ack(d_ack),
    .b_req(b_req), .d_hs(d_hs), .c_hs(c_hs),
    .d_lp_p(d_lp_p), .d_lp_n(d_lp_n), .c_lp_p(c_lp_p), .c_lp_n(c_lp_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pe(input logic [1:0] dl, input logic [1:0] cl, input logic dh, input logic ch);
    exp_q.push_back({dl, cl, dh, ch, 1'b0});
  endtask

  // One cycle with the clock lane in HS and toggling.
  task automatic pt(input logic [1:0] dl, input logic dh);
    pe(dl, 2'b00, dh, tg);
    tg = ~tg;
  endtask

  task automatic push_burst(input int n);
    int         nb;
    logic [7:0] b;
    logic       last;
    nb = (n > DEPTH) ? DEPTH : n;
    repeat (T_LPX) pe(2'b11, 2'b01, 1'b0, 1'b0);
    repeat (T_LPX) pe(2'b11, 2'b00, 1'b0, 1'b0);
    repeat (T_PREP + T_ZERO) pe(2'b11, 2'b00, 1'b0, 1'b0);
    tg = 1'b1;
    repeat (T_CLK_PRE) pt(2'b11, 1'b0);
    repeat (T_LPX) pt(2'b01, 1'b0);
    repeat (T_LPX) pt(2'b00, 1'b0);
    repeat (T_PREP + T_ZERO) pt(2'b00, 1'b0);
    b = 8'hB8;
    for (int i = 0; i < 8; i++) pt(2'b00, b[i]);
    last = b[7];
    for (int k = 0; k < nb; k++) begin
      b = frm[k];
      for (int i = 0; i < 8; i++) pt(2'b00, b[i]);
      last = b[7];
    end
    repeat (T_TRAIL) pt(2'b00, ~last);
    pt(2'b11, 1'b0);
    repeat (T_CLK_POST) pt(2'b11, 1'b0);
    repeat (T_TRAIL) pe(2'b11, 2'b00, 1'b0, 1'b0);
    repeat (5) pe(2'b11, 2'b11, 1'b0, 1'b0);
  endtask

  task automatic send_frame();
    int acks;
    acks = 0;
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk);
      b_req = 1'b1; d_req = 1'b1; d_in = frm[i];
      #1;
      if (d_ack) acks++;
    end
    @(negedge clk);
    d_req = 1'b0; b_req = 1'b0;
    chk("ack_count", 32'(acks), 32'(frm.size()));
    push_burst(frm.size());
  endtask

  // poke: drive frame requests mid-burst, which must be ignored.
  task automatic run_sb(input string tag, input int max_n, input bit poke);
    for (int j = 0; j < max_n && exp_q.size() > 0; j++) begin
      @(negedge clk);
      if (poke) begin
        if (j >= 20 && j < 40) begin d_req = 1'b1; b_req = 1'b1; d_in = 8'hEE; end
        else begin d_req = 1'b0; b_req = 1'b0; end
      end
      #1;
      chk(tag, 32'(obs), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 chk("reset_state", 32'(obs), 32'(IDLE_V));
    @(negedge clk);
    rst = 1'b1;
    repeat (1000) exp_q.push_back(IDLE_V);
    run_sb("idle_after_reset", 1000, 1'b0);

    frm.delete(); frm.push_back(8'hC0);
    send_frame();
    run_sb("burst_c0", 100000, 1'b1);

    frm.delete(); frm.push_back(8'h01); frm.push_back(8'h80); frm.push_back(8'hFF);
    send_frame();
    run_sb("burst_3b", 100000, 1'b0);

    @(negedge clk); b_req = 1'b1;
    repeat (2) @(negedge clk);
    b_req = 1'b0;
    repeat (60) exp_q.push_back(IDLE_V);
    run_sb("empty_frame", 60, 1'b0);

    frm.delete();
    for (int i = 0; i < DEPTH + 4; i++) frm.push_back(8'(i * 37 + 5));
    send_frame();
    run_sb("burst_overflow", 100000, 1'b0);

    frm.delete();
    frm.push_back(8'h11); frm.push_back(8'h22); frm.push_back(8'h33); frm.push_back(8'h44);
    send_frame();
    run_sb("burst_pre_rst", 104 + 12, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_async", 32'(obs), 32'(IDLE_V));
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1 chk("rst_hold", 32'(obs), 32'(IDLE_V));
    rst = 1'b1;

    frm.delete(); frm.push_back(8'h5A);
    send_frame();
    run_sb("burst_after_rst", 100000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
